// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender with rotated imm8, carry and flush
// Ports:
//   clk, reset (async, active-high), flush (sync squash of both stages)
//   in_valid/in_ready, Instr, ImmSrc       : upstream handshake and immediate fields
//   out_valid/out_ready, ExtImm            : downstream handshake and extended immediate
//   imm_carry, carry_valid                 : rotator carry-out and its qualifier
module imm_extend_pipe #(
    parameter int DATA_W   = 32,
    parameter int INSTR_W  = 24,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [1:0]         ImmSrc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ExtImm,
    output logic               imm_carry,
    output logic               carry_valid
);
    logic              r_s1v;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_pre;
    logic [3:0]        r_rot;
    logic              r_s2v;
    logic [DATA_W-1:0] r_ext;
    logic              r_carry;
    logic              r_cv;

    logic                w_s2_free;
    logic                w_accept;
    logic                w_move;
    logic [DATA_W-1:0]   w_br;
    logic [DATA_W-1:0]   w_pre;
    logic [31:0]         w_amt;
    logic [31:0]         w_sh;
    logic [2*DATA_W-1:0] w_dbl;
    logic [DATA_W-1:0]   w_rot;
    logic                w_rot_on;

    assign w_s2_free = !r_s2v || out_ready;
    assign in_ready  = !r_s1v || w_s2_free;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_move    = r_s1v && w_s2_free && !flush;

    always_comb begin
        w_br  = {{(DATA_W-INSTR_W){Instr[INSTR_W-1]}}, Instr} << BR_SHIFT;
        w_pre = (ImmSrc == 2'b00) ? {{(DATA_W-8){1'b0}}, Instr[7:0]} :
                (ImmSrc == 2'b01) ? {{(DATA_W-12){1'b0}}, Instr[11:0]} :
                (ImmSrc == 2'b10) ? w_br :
                                    {{(DATA_W-8){1'b0}}, Instr[11:8], Instr[3:0]};
    end

    // Only mode 00 rotates; other modes carry a zero rotate so stage 2 passes them through.
    always_comb begin
        w_amt    = {27'd0, r_rot, 1'b0};
        w_sh     = (w_amt >= 32'(DATA_W)) ? w_amt - 32'(DATA_W) : w_amt;
        w_dbl    = {r_pre, r_pre} >> w_sh;
        w_rot    = w_dbl[DATA_W-1:0];
        w_rot_on = (r_mode == 2'b00) && (r_rot != 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1v  <= 1'b0;
            r_mode <= 2'b00;
            r_pre  <= '0;
            r_rot  <= 4'd0;
        end else begin
            r_s1v <= flush ? 1'b0 : (w_accept || (r_s1v && !w_move));
            if (w_accept) begin
                r_mode <= ImmSrc;
                r_pre  <= w_pre;
                r_rot  <= (ImmSrc == 2'b00) ? Instr[11:8] : 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2v   <= 1'b0;
            r_ext   <= '0;
            r_carry <= 1'b0;
            r_cv    <= 1'b0;
        end else begin
            r_s2v <= flush ? 1'b0 : (w_move || (r_s2v && !out_ready));
            if (w_move) begin
                r_ext   <= w_rot;
                r_carry <= w_rot_on && w_rot[DATA_W-1];
                r_cv    <= w_rot_on;
            end
        end
    end

    assign out_valid   = r_s2v;
    assign ExtImm      = r_ext;
    assign imm_carry   = r_carry;
    assign carry_valid = r_cv;
endmodule
